// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : Host-to-device PS2 transmitter. Runs the request-to-send
//            sequence, shifts one command byte out on device clocks with odd
//            parity and a stop bit, then checks the device acknowledge.
//            Optional build macro PS2_TX_ACK_CHECK_EN: when defined, a NACK
//            (data high on the acknowledge edge) reports tx_error; when
//            undefined the acknowledge bit is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    // One counter serves the inhibit, request and timeout phases, so it is
    // sized for the largest of the three limits.
    localparam int C_MAX_AB = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int C_MAX    = (C_MAX_AB > TIMEOUT_CYCLES) ? C_MAX_AB : TIMEOUT_CYCLES;
    localparam int C_CNT_W  = $clog2(C_MAX) + 1;

    localparam logic [C_CNT_W-1:0] C_INH_LAST = C_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_REQ_LAST = C_CNT_W'(REQ_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_TO_LAST  = C_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         C_STOP_IDX = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t              r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [3:0]          r_bit_cnt;
    logic [9:0]          r_frame;
    logic                r_ack_ok;

    logic                r_clk_meta;
    logic                r_clk_sync;
    logic                r_clk_prev;
    logic                r_data_meta;
    logic                r_data_sync;

    logic                w_fall;
    logic [C_CNT_W-1:0]  w_cnt_inc;
    logic [3:0]          w_bit_inc;
    logic                w_ack_sample;

    // Device falling edge, seen on the synchronized clock line.
    assign w_fall = r_clk_prev & ~r_clk_sync;

    // Counters hold at all-ones instead of wrapping.
    assign w_cnt_inc = (r_cnt == {C_CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_bit_inc = (r_bit_cnt == 4'hF) ? r_bit_cnt : r_bit_cnt + 1'b1;

`ifdef PS2_TX_ACK_CHECK_EN
    // Device pulls data low to acknowledge.
    assign w_ack_sample = ~r_data_sync;
`else
    // Acknowledge bit is ignored; every frame that completes is a success.
    assign w_ack_sample = 1'b1;
`endif

    // Two-flop synchronizers for the asynchronous PS2 lines plus edge history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_meta  <= 1'b0;
            r_clk_sync  <= 1'b0;
            r_clk_prev  <= 1'b0;
            r_data_meta <= 1'b0;
            r_data_sync <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    // Transmit sequencer with registered line enables and status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_frame     <= '0;
            r_ack_ok    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_frame    <= {1'b1, ~^tx_data, tx_data};
                        r_cnt      <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_busy    <= 1'b1;
                        r_state    <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (r_cnt == C_INH_LAST) begin
                        r_cnt       <= '0;
                        ps2_data_oe <= 1'b1;
                        r_state     <= S_REQ;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_REQ: begin
                    if (r_cnt == C_REQ_LAST) begin
                        r_cnt      <= '0;
                        r_bit_cnt  <= '0;
                        ps2_clk_oe <= 1'b0;
                        r_state    <= S_SEND;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                default: begin
                    // SEND, ACK and WAIT_IDLE share the inter-edge timeout.
                    if (!w_fall && (r_cnt == C_TO_LAST)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_busy     <= 1'b0;
                        tx_error    <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= w_fall ? '0 : w_cnt_inc;
                        if (r_state == S_SEND) begin
                            if (w_fall) begin
                                ps2_data_oe <= ~r_frame[0];
                                r_frame     <= {1'b0, r_frame[9:1]};
                                r_bit_cnt   <= w_bit_inc;
                                if (r_bit_cnt == C_STOP_IDX) begin
                                    r_state <= S_ACK;
                                end
                            end
                        end else if (r_state == S_ACK) begin
                            if (w_fall) begin
                                r_ack_ok <= w_ack_sample;
                                r_state  <= S_WAIT_IDLE;
                            end
                        end else begin
                            // Wait for the device to release both lines.
                            if (r_clk_sync && r_data_sync) begin
                                tx_done  <= r_ack_ok;
                                tx_error <= ~r_ack_ok;
                                tx_busy  <= 1'b0;
                                r_state  <= S_IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Self-checking bench for ps2_host_tx with a PS2 device model.
//            Expected completions and frames are queued at stimulus time and
//            compared when the DUT / device model presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int REQ  = 5;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clock;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    logic       dev_clk;
    logic       dev_data;

    int n_pass  = 0;
    int n_total = 0;

    // 0 = tx_done expected, 1 = tx_error expected
    logic        exp_q[$];
    logic [10:0] frame_q[$];

    assign ps2_clk_in  = ~ps2_clk_oe  & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Completion monitor: every done/error pulse is matched against the queue.
    always @(negedge clock) begin
        if (!reset && (tx_done || tx_error)) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got done=%0b error=%0b expected none", tx_done, tx_error);
            end else begin
                logic e;
                e = exp_q.pop_front();
                if ((tx_done ^ tx_error) && (tx_error == e)) n_pass++;
                else $display("FAIL completion: got done=%0b error=%0b expected error=%0b", tx_done, tx_error, e);
            end
        end
    end

    // Issue a start and check the request-to-send timing up to clock release.
    task automatic send_cmd(input logic [7:0] d);
        int c;
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clock);
        #1;
        tx_start = 1'b0;
        chk("accept_busy_clkoe", {30'd0, tx_busy, ps2_clk_oe}, 32'h3);
        c = 0;
        while (!ps2_data_oe && c < 1000) begin
            @(posedge clock); #1; c++;
        end
        chk("inhibit_len", c, INH);
        c = 0;
        while (ps2_clk_oe && c < 1000) begin
            @(posedge clock); #1; c++;
        end
        chk("req_len", c, REQ);
    endtask

    // Device model: generates nfalls clock pulses, captures the frame on
    // rising edges, drives ack_bit on the 11th falling edge.
    task automatic dev_run(input logic ack_bit, input int nfalls, input logic check_frame);
        logic [10:0] bits;
        logic [10:0] exp;
        bits    = '0;
        bits[0] = ps2_data_in;
        repeat (4) @(posedge clock);
        #1;
        for (int k = 1; k <= 10; k++) begin
            if (k <= nfalls) begin
                dev_clk = 1'b0;
                repeat (HALF) @(posedge clock);
                #1;
                dev_clk = 1'b1;
                bits[k] = ps2_data_in;
                repeat (HALF) @(posedge clock);
                #1;
            end
        end
        if (nfalls >= 11) begin
            dev_data = ack_bit;
            dev_clk  = 1'b0;
            repeat (HALF) @(posedge clock);
            #1;
            dev_clk = 1'b1;
            repeat (HALF) @(posedge clock);
            #1;
            dev_data = 1'b1;
        end
        if (check_frame) begin
            if (frame_q.size() == 0) begin
                chk("frame_queue", 32'd0, 32'd1);
            end else begin
                exp = frame_q.pop_front();
                chk("frame_bits", {21'd0, bits}, {21'd0, exp});
            end
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (tx_busy && c < 2000) begin
            @(posedge clock); #1; c++;
        end
        chk("busy_clear", {31'd0, tx_busy}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;

        // 0xED with ACK
        exp_q.push_back(1'b0);
        frame_q.push_back(frame_of(8'hED));
        send_cmd(8'hED);
        dev_run(1'b0, 11, 1'b1);
        wait_idle();

        // Parity 0 then parity 1
        exp_q.push_back(1'b0);
        frame_q.push_back(frame_of(8'h07));
        send_cmd(8'h07);
        dev_run(1'b0, 11, 1'b1);
        wait_idle();
        exp_q.push_back(1'b0);
        frame_q.push_back(frame_of(8'h00));
        send_cmd(8'h00);
        dev_run(1'b0, 11, 1'b1);
        wait_idle();

        // Device never clocks: timeout counted from clock release
        exp_q.push_back(1'b1);
        send_cmd(8'hA5);
        c = 0;
        while (!tx_error && c < 1000) begin
            @(posedge clock); #1; c++;
        end
        chk("timeout_len", c, TO);
        chk("timeout_release", {29'd0, ps2_clk_oe, ps2_data_oe, tx_busy}, 32'd0);
        repeat (3) @(posedge clock);
        #1;

        // NACK from device
`ifdef PS2_TX_ACK_CHECK_EN
        exp_q.push_back(1'b1);
`else
        exp_q.push_back(1'b0);
`endif
        frame_q.push_back(frame_of(8'h3C));
        send_cmd(8'h3C);
        dev_run(1'b1, 11, 1'b1);
        wait_idle();

        // tx_start during SEND is ignored
        exp_q.push_back(1'b0);
        frame_q.push_back(frame_of(8'hED));
        send_cmd(8'hED);
        fork
            dev_run(1'b0, 11, 1'b1);
            begin
                repeat (100) @(posedge clock);
                @(negedge clock);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
            end
        join
        wait_idle();
        repeat (10) @(posedge clock);
        #1;
        chk("no_restart", {30'd0, tx_busy, ps2_clk_oe}, 32'd0);

        // Reset after the 4th data bit aborts silently
        send_cmd(8'hED);
        dev_run(1'b0, 4, 1'b0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("reset_async_release", {29'd0, ps2_clk_oe, ps2_data_oe, tx_busy}, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;

        exp_q.push_back(1'b0);
        frame_q.push_back(frame_of(8'hFF));
        send_cmd(8'hFF);
        dev_run(1'b0, 11, 1'b1);
        wait_idle();

        repeat (20) @(posedge clock);
        #1;
        chk("pending_completions", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
